// File: rtl/pipe_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_pkg : shared pipeline-register types and constants           |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
package pipe_pkg;

    localparam int unsigned C_WIDTH = 32;
    localparam logic [C_WIDTH-1:0] C_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [C_WIDTH-1:0] pc;
        logic [C_WIDTH-1:0] pc4;
        logic [C_WIDTH-1:0] instr;
    } ifid_t;

endpackage
`default_nettype wire

// File: rtl/ifid1_entry.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ifid1_entry : one valid bit plus a {pc, pc4, instr} payload        |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module ifid1_entry
    import pipe_pkg::*;
#(
    parameter int DATA_W = 3 * C_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Clear beats load; the payload is left stale on clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/ifid1.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ifid1 : IF/ID stage with a 2-entry skid buffer and flush           |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
module ifid1
    import pipe_pkg::*;
#(
    parameter int               WIDTH = C_WIDTH,
    parameter logic [WIDTH-1:0] NOP   = WIDTH'(C_NOP)
) (
    input  logic             clkifid1,
    input  logic             rstnifid1,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] pc4_in,
    input  logic [WIDTH-1:0] instr_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc4_out,
    output logic [WIDTH-1:0] instr_out,
    output logic [1:0]       count
);

    localparam int DATA_W = 3 * WIDTH;

    logic              w_main_valid;
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_main_data;
    logic [DATA_W-1:0] w_skid_data;
    logic [DATA_W-1:0] w_in_data;
    logic [DATA_W-1:0] w_main_din;
    logic              w_accept;
    logic              w_drain;
    logic              w_main_load;
    logic              w_main_clear;
    logic              w_skid_load;
    logic              w_skid_clear;

    assign w_in_data = {pc_in, pc4_in, instr_in};
    assign w_accept  = in_valid & in_ready;
    assign w_drain   = w_main_valid & out_ready;

    // Main refills from skid when skid is occupied, else straight from fetch.
    assign w_main_din   = w_skid_valid ? w_skid_data : w_in_data;
    assign w_main_load  = ~flush & ((w_drain & w_skid_valid) |
                                    (w_accept & (~w_main_valid | w_drain)));
    assign w_main_clear = flush | (w_drain & ~w_skid_valid & ~w_accept);

    assign w_skid_load  = ~flush & w_accept & w_main_valid & ~w_drain;
    assign w_skid_clear = flush | (w_drain & w_skid_valid);

    ifid1_entry #(.DATA_W(DATA_W)) u_main (
        .clk     (clkifid1),
        .rst_n   (rstnifid1),
        .i_load  (w_main_load),
        .i_clear (w_main_clear),
        .i_data  (w_main_din),
        .o_valid (w_main_valid),
        .o_data  (w_main_data)
    );

    ifid1_entry #(.DATA_W(DATA_W)) u_skid (
        .clk     (clkifid1),
        .rst_n   (rstnifid1),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_data  (w_in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    // Ready depends only on registered state so decode stalls never reach fetch.
    assign in_ready  = ~w_skid_valid;
    assign out_valid = w_main_valid;
    assign pc_out    = w_main_data[3*WIDTH-1:2*WIDTH];
    assign pc4_out   = w_main_data[2*WIDTH-1:WIDTH];
    assign instr_out = w_main_valid ? w_main_data[WIDTH-1:0] : NOP;
    assign count     = {1'b0, w_main_valid} + {1'b0, w_skid_valid};

endmodule
`default_nettype wire
